logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's 4-bit combinational AND/OR unit.
- Computes one of eight bitwise operations on WIDTH-bit operands, with a valid/ready input handshake and a DEPTH-entry output FIFO.
- Optional accumulate mode chains results.
- Sits between operand sequencers and downstream consumers that may apply backpressure.

Parameters:
- WIDTH, 4, operand/result width in bits (>=1)
- DEPTH, 2, output FIFO entries (power of two, >=2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- inValid  input  1  operand transaction offered
- inReady  output  1  unit can accept; combinational = (FIFO count < DEPTH)
- aIn  input  WIDTH  operand A
- bIn  input  WIDTH  operand B
- opSel  input  3  operation select
- accMode  input  1  1 = replace A with accumulator
- outValid  output  1  FIFO non-empty
- outReady  input  1  consumer takes head entry
- out  output  WIDTH  head result
- opCode  output  3  opSel of head entry
- isErr  output  1  head entry carried an illegal opSel

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - Clears FIFO (count=0, pointers=0) and accumulator to 0.
  - Outputs after reset edge: outValid=0, inReady=1, out=0, opCode=0, isErr=0.
  - Reset mid-operation discards all buffered entries; in-flight handshakes that cycle are ignored.
- Accept: inValid && inReady at a rising edge.
  - Operand A = accMode ? acc : aIn.
- Operations (all bitwise, full WIDTH):
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 PASS A.
  - 7 is illegal: result = 0, isErr = 1.
  - Never drive X on any output.
- Accumulator:
  - Updated at the accept edge with the result of every legal transaction, whether or not accMode is set.
  - Illegal transactions leave acc unchanged.
  - Back-to-back accMode transactions see the previous result with no bubble.
- Latency: a transaction accepted at edge N is visible at the FIFO head (outValid=1) from edge N if the FIFO was empty; it is valid in the cycle after edge N.
- Output: head entry {out, opCode, isErr} is held stable while outValid && !outReady.
  - Pop occurs on outValid && outReady at the edge.
  - When outValid=0, out/opCode/isErr read 0.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When the FIFO is full, inReady=0, so no push happens even if a pop occurs the same cycle (no pass-through).
  - When empty, a push and a pop cannot coincide because outValid=0.
- Pointers wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits wide and never exceeds DEPTH or goes below 0.
- inValid while inReady=0: no state change; the source holds its data.

Optional Feature:
- Macro: LOGIC_UNIT_STATS_EN
- When defined, two extra ports are added:
  - errCnt output 8: saturating count of accepted illegal transactions, stops at 255.
  - txCnt output 16: wrapping count of accepted transactions.
  - Both reset to 0 on rst; both increment at the accept edge.
- When undefined: these ports and their counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> outValid=0, inReady=1, out=0, isErr=0.
- WIDTH=4, aIn=4'b1100, bIn=4'b1010, opSel 0..6 with outReady=1 -> out = 1000, 1110, 0110, 0111, 0001, 1001, 1100, each one cycle after accept, isErr=0.
- opSel=7, aIn=F, bIn=F -> out=0, isErr=1, opCode=7; acc unchanged (verify with a following accMode PASS that outputs the prior acc).
- Accumulate: XOR with aIn=3, bIn=5 (result 6), then accMode=1 XOR bIn=F -> 9, then accMode=1 AND bIn=C -> 8; all back-to-back.
- Backpressure, DEPTH=2: outReady=0, push 3 transactions -> inReady drops to 0 after 2 accepts, third is held. Raise outReady -> entries drain in order, third is accepted the cycle after the first pop.
- With LOGIC_UNIT_STATS_EN: 300 illegal transactions -> errCnt=255, txCnt=300. Assert rst mid-stream -> both counters and the FIFO are 0 the next cycle.

Source files
------------

// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The unit takes the slave view; a source/consumer takes the master view.
interface logic_unit_pipe_if #(
  parameter int unsigned WIDTH = 4
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] aIn;
  logic [WIDTH-1:0] bIn;
  logic [2:0]       opSel;
  logic             accMode;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] out;
  logic [2:0]       opCode;
  logic             isErr;

  modport master (
    output inValid, aIn, bIn, opSel, accMode, outReady,
    input  inReady, outValid, out, opCode, isErr
  );

  modport slave (
    input  inValid, aIn, bIn, opSel, accMode, outReady,
    output inReady, outValid, out, opCode, isErr
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit: eight-way op select, accumulator, DEPTH-entry output FIFO.
// Define LOGIC_UNIT_STATS_EN to add the errCnt/txCnt statistics ports.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  logic_unit_pipe_if.slave    bus
`ifdef LOGIC_UNIT_STATS_EN
  ,
  output logic [7:0]          errCnt,
  output logic [15:0]         txCnt
`endif
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_XOR     = 3'd2,
    OP_NAND    = 3'd3,
    OP_NOR     = 3'd4,
    OP_XNOR    = 3'd5,
    OP_PASS    = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [2:0]       op;
    logic             err;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] result;
  logic             illegal;
  logic             push;
  logic             pop;

  assign bus.inReady  = (count < FULL);
  assign bus.outValid = (count != '0);
  assign push         = bus.inValid && bus.inReady;
  assign pop          = bus.outValid && bus.outReady;

  // Head fields are masked to zero when empty so no stale or X data escapes.
  assign bus.out    = bus.outValid ? mem[rd_ptr].res : '0;
  assign bus.opCode = bus.outValid ? mem[rd_ptr].op  : '0;
  assign bus.isErr  = bus.outValid ? mem[rd_ptr].err : 1'b0;

  always_comb begin
    op_a    = bus.accMode ? acc : bus.aIn;
    result  = '0;
    illegal = 1'b0;
    case (op_e'(bus.opSel))
      OP_AND:     result = op_a & bus.bIn;
      OP_OR:      result = op_a | bus.bIn;
      OP_XOR:     result = op_a ^ bus.bIn;
      OP_NAND:    result = ~(op_a & bus.bIn);
      OP_NOR:     result = ~(op_a | bus.bIn);
      OP_XNOR:    result = ~(op_a ^ bus.bIn);
      OP_PASS:    result = op_a;
      OP_ILLEGAL: illegal = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      acc    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{res: result, op: bus.opSel, err: illegal};
        wr_ptr      <= wr_ptr + 1'b1;
        if (!illegal) acc <= result;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef LOGIC_UNIT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      errCnt <= '0;
      txCnt  <= '0;
    end else if (push) begin
      txCnt <= txCnt + 1'b1;
      if (illegal && (errCnt != '1)) errCnt <= errCnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe (WIDTH=4, DEPTH=2): vector table,
// directed backpressure/reset sequences and randomized traffic against a queue model.
module tb_logic_unit_pipe;
  localparam int W = 4;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(W)) bus();

`ifdef LOGIC_UNIT_STATS_EN
  logic [7:0]  errCnt;
  logic [15:0] txCnt;
`endif

  logic_unit_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef LOGIC_UNIT_STATS_EN
    ,
    .errCnt(errCnt),
    .txCnt(txCnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] r;
    logic [2:0]   op;
    logic         err;
  } ent_t;

  ent_t         q[$];
  logic [W-1:0] m_acc;
  int           m_err;
  int           m_tx;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         am;
    logic [W-1:0] exp_out;
    logic         exp_err;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a;
      default: return '0;
    endcase
  endfunction

  task automatic model_clear();
    q.delete();
    m_acc = '0;
    m_err = 0;
    m_tx  = 0;
  endtask

  task automatic check_model();
    logic v;
    v = (q.size() > 0);
    chk("outValid", bus.outValid, v);
    chk("inReady", bus.inReady, q.size() < D);
    chk("out", bus.out, v ? q[0].r : '0);
    chk("opCode", bus.opCode, v ? q[0].op : '0);
    chk("isErr", bus.isErr, v ? q[0].err : 1'b0);
`ifdef LOGIC_UNIT_STATS_EN
    chk("errCnt", errCnt, (m_err > 255) ? 255 : m_err);
    chk("txCnt", txCnt, m_tx % 65536);
`endif
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic am, input logic ordy);
    logic         take;
    logic         give;
    logic [W-1:0] opa;
    logic [W-1:0] r;
    bus.inValid  = v;
    bus.aIn      = a;
    bus.bIn      = b;
    bus.opSel    = op;
    bus.accMode  = am;
    bus.outReady = ordy;
    take = v && (q.size() < D);
    give = ordy && (q.size() > 0);
    if (give) void'(q.pop_front());
    if (take) begin
      opa = am ? m_acc : a;
      r   = ref_res(opa, b, op);
      q.push_back('{r: r, op: op, err: (op == 3'd7)});
      if (op != 3'd7) m_acc = r;
      m_tx++;
      if (op == 3'd7) m_err++;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 4'hF, 4'hF, 3'd7, 1'b0, 1'b1);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    model_clear();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
    check_model();
    chk("rst_outValid", bus.outValid, 1'b0);
    chk("rst_inReady", bus.inReady, 1'b1);
  endtask

  initial begin
    tbl[0]  = '{4'hC, 4'hA, 3'd0, 1'b0, 4'b1000, 1'b0};
    tbl[1]  = '{4'hC, 4'hA, 3'd1, 1'b0, 4'b1110, 1'b0};
    tbl[2]  = '{4'hC, 4'hA, 3'd2, 1'b0, 4'b0110, 1'b0};
    tbl[3]  = '{4'hC, 4'hA, 3'd3, 1'b0, 4'b0111, 1'b0};
    tbl[4]  = '{4'hC, 4'hA, 3'd4, 1'b0, 4'b0001, 1'b0};
    tbl[5]  = '{4'hC, 4'hA, 3'd5, 1'b0, 4'b1001, 1'b0};
    tbl[6]  = '{4'hC, 4'hA, 3'd6, 1'b0, 4'b1100, 1'b0};
    tbl[7]  = '{4'hF, 4'hF, 3'd7, 1'b0, 4'b0000, 1'b1};
    tbl[8]  = '{4'h3, 4'h0, 3'd6, 1'b1, 4'b1100, 1'b0};
    tbl[9]  = '{4'h3, 4'h5, 3'd2, 1'b0, 4'b0110, 1'b0};
    tbl[10] = '{4'h0, 4'hF, 3'd2, 1'b1, 4'b1001, 1'b0};
    tbl[11] = '{4'hF, 4'hC, 3'd0, 1'b1, 4'b1000, 1'b0};
    tbl[12] = '{4'h5, 4'h5, 3'd1, 1'b0, 4'b0101, 1'b0};

    model_clear();
    bus.inValid = 1'b0; bus.aIn = '0; bus.bIn = '0;
    bus.opSel = '0; bus.accMode = 1'b0; bus.outReady = 1'b0;

    do_reset(2);
    chk("rst_out", bus.out, 0);
    chk("rst_opCode", bus.opCode, 0);
    chk("rst_isErr", bus.isErr, 0);

    // Back-to-back table: entry k is checked at the head one cycle after its accept.
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      check_model();
      if (k > 0) begin
        chk($sformatf("tbl%0d_valid", k-1), bus.outValid, 1'b1);
        chk($sformatf("tbl%0d_out", k-1), bus.out, tbl[k-1].exp_out);
        chk($sformatf("tbl%0d_op", k-1), bus.opCode, tbl[k-1].op);
        chk($sformatf("tbl%0d_err", k-1), bus.isErr, tbl[k-1].exp_err);
      end
      if (k < 13) begin
        chk($sformatf("tbl%0d_rdy", k), bus.inReady, 1'b1);
        drive(1'b1, tbl[k].a, tbl[k].b, tbl[k].op, tbl[k].am, 1'b1);
      end else begin
        drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
      end
    end
    @(negedge clk);
    check_model();
    chk("drained_valid", bus.outValid, 1'b0);

    // Backpressure: third push waits until the cycle after the first pop.
    do_reset(1);
    @(negedge clk); check_model(); chk("bp_rdy0", bus.inReady, 1'b1);
    drive(1'b1, 4'hC, 4'hA, 3'd0, 1'b0, 1'b0);
    @(negedge clk); check_model(); chk("bp_rdy1", bus.inReady, 1'b1);
    drive(1'b1, 4'hC, 4'hA, 3'd1, 1'b0, 1'b0);
    @(negedge clk); check_model(); chk("bp_full", bus.inReady, 1'b0);
    drive(1'b1, 4'hC, 4'hA, 3'd2, 1'b0, 1'b0);
    @(negedge clk); check_model(); chk("bp_hold_rdy", bus.inReady, 1'b0);
    chk("bp_head1", bus.out, 4'h8);
    drive(1'b1, 4'hC, 4'hA, 3'd2, 1'b0, 1'b1);
    @(negedge clk); check_model(); chk("bp_rdy_after_pop", bus.inReady, 1'b1);
    chk("bp_head2", bus.out, 4'hE);
    drive(1'b1, 4'hC, 4'hA, 3'd2, 1'b0, 1'b1);
    @(negedge clk); check_model(); chk("bp_head3", bus.out, 4'h6);
    chk("bp_head3_op", bus.opCode, 3'd2);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1);
    @(negedge clk); check_model(); chk("bp_empty", bus.outValid, 1'b0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      check_model();
      drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end

    // Mid-stream reset with a full FIFO and a handshake offered.
    @(negedge clk); check_model();
    drive(1'b1, 4'h1, 4'h2, 3'd1, 1'b0, 1'b0);
    @(negedge clk); check_model();
    drive(1'b1, 4'h1, 4'h2, 3'd1, 1'b0, 1'b0);
    do_reset(1);
    chk("midrst_out", bus.out, 0);

`ifdef LOGIC_UNIT_STATS_EN
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check_model();
      drive(1'b1, 4'hF, 4'hF, 3'd7, 1'b0, 1'b1);
    end
    @(negedge clk);
    check_model();
    chk("errCnt_sat", errCnt, 8'd255);
    chk("txCnt_300", txCnt, 16'd300);
    drive(1'b1, 4'h3, 4'h1, 3'd0, 1'b0, 1'b0);
    do_reset(1);
    chk("rst_errCnt", errCnt, 0);
    chk("rst_txCnt", txCnt, 0);
`endif

    @(negedge clk);
    check_model();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
